// File: rtl/hex_display_pager_pkg.sv
// Shared constants and glyph table for the paged
// seven-segment front panel.
package hex_display_pager_pkg;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_STEP   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit0=a .. bit6=g
  function automatic logic [6:0] hex_glyph(
    input logic [3:0] n
  );
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-TICKS counter with a one-cycle pulse on
// the terminal count and a synchronous clear.
module tick_divider #(
  parameter int TICKS = 4
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iCLR,
  output logic oTICK
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] r_cnt;

  assign oTICK = (r_cnt == LAST);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_cnt <= '0;
    end else if (iCLR || oTICK) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_pager.sv
// Multi-page hex front panel: page select, auto
// scroll, manual step, blink and zero blanking.
module hex_display_pager
  import hex_display_pager_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int NUM_PAGES   = 4,
  parameter int PAGE_TICKS  = 50000000,
  parameter int BLINK_TICKS = 12500000
) (
  input  logic                            iCLK,
  input  logic                            iRST,
  input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] iDATA,
  input  logic [1:0]                      iMODE,
  input  logic [3:0]                      iPAGE_SEL,
  input  logic                            iSTEP,
  input  logic                            iBLANK_LZ,
  input  logic [NUM_DIGITS-1:0]           iBLINK_MASK,
  output logic [NUM_DIGITS*7-1:0]         oSEG,
  output logic [3:0]                      oPAGE,
  output logic                            oWRAP
);

  localparam int DW = NUM_DIGITS * 4;
  localparam logic [3:0] LAST_PAGE = 4'(NUM_PAGES - 1);

  logic [1:0]              r_mode_q;
  logic                    r_step_q;
  logic [3:0]              r_page;
  logic                    r_wrap;
  logic                    r_phase;
  logic [NUM_DIGITS*7-1:0] r_seg;

  logic                    w_mode_chg;
  logic                    w_auto;
  logic                    w_manual;
  logic                    w_page_tick;
  logic                    w_blink_tick;
  logic                    w_adv;
  logic                    w_wrap_nxt;
  logic                    w_phase_nxt;
  logic [3:0]              w_page_inc;
  logic [3:0]              w_page_nxt;
  logic [DW-1:0]           w_word;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS*7-1:0] w_seg_nxt;

  assign w_mode_chg = (iMODE != r_mode_q);
  assign w_auto     = (iMODE == MODE_AUTO);
  assign w_manual   = (iMODE == MODE_STEP);

  tick_divider #(.TICKS(PAGE_TICKS)) u_page_div (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iCLR  (!w_auto || w_mode_chg),
    .oTICK (w_page_tick)
  );

  tick_divider #(.TICKS(BLINK_TICKS)) u_blink_div (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iCLR  (1'b0),
    .oTICK (w_blink_tick)
  );

  // A mode switch swallows any same-cycle tick or step edge
  assign w_adv = !w_mode_chg &&
                 ((w_auto && w_page_tick) ||
                  (w_manual && iSTEP && !r_step_q));

  assign w_page_inc = (r_page >= LAST_PAGE) ?
                      4'd0 : r_page + 4'd1;

  always_comb begin
    w_page_nxt = r_page;
    w_wrap_nxt = 1'b0;
    if (!w_auto && !w_manual) begin
      w_page_nxt = (iPAGE_SEL > LAST_PAGE) ?
                   LAST_PAGE : iPAGE_SEL;
    end else if (w_adv) begin
      w_page_nxt = w_page_inc;
      w_wrap_nxt = (r_page >= LAST_PAGE);
    end
  end

  assign w_phase_nxt = r_phase ^ w_blink_tick;

  always_comb begin
    w_word = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (w_page_nxt == 4'(p)) begin
        w_word = iDATA[p*DW +: DW];
      end
    end
  end

  always_comb begin
    logic seen;
    seen = 1'b0;
    w_lz = '0;
    for (int d = NUM_DIGITS - 1; d > 0; d--) begin
      if (w_word[d*4 +: 4] != 4'd0) seen = 1'b1;
      w_lz[d] = iBLANK_LZ && !seen;
    end
  end

  always_comb begin
    w_seg_nxt = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_seg_nxt[d*7 +: 7] =
        ((w_phase_nxt && iBLINK_MASK[d]) || w_lz[d]) ?
        SEG_BLANK : hex_glyph(w_word[d*4 +: 4]);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_mode_q <= MODE_STATIC;
      r_step_q <= 1'b0;
      r_page   <= 4'd0;
      r_wrap   <= 1'b0;
      r_phase  <= 1'b0;
      r_seg    <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_mode_q <= iMODE;
      r_step_q <= iSTEP;
      r_page   <= w_page_nxt;
      r_wrap   <= w_wrap_nxt;
      r_phase  <= w_phase_nxt;
      r_seg    <= w_seg_nxt;
    end
  end

  assign oSEG  = r_seg;
  assign oPAGE = r_page;
  assign oWRAP = r_wrap;

endmodule

// File: tb/tb_hex_display_pager.sv
// Directed bench for hex_display_pager with
// 8 digits, 3 pages, 4-cycle pages, 3-cycle blink.
module tb_hex_display_pager;

  localparam int ND = 8;
  localparam int NP = 3;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic [NP*ND*4-1:0] iDATA;
  logic [1:0]       iMODE;
  logic [3:0]       iPAGE_SEL;
  logic             iSTEP;
  logic             iBLANK_LZ;
  logic [ND-1:0]    iBLINK_MASK;
  logic [ND*7-1:0]  oSEG;
  logic [3:0]       oPAGE;
  logic             oWRAP;

  int ntot = 0;
  int npass = 0;

  localparam logic [48:0] UP0 =
    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  hex_display_pager #(
    .NUM_DIGITS (ND),
    .NUM_PAGES  (NP),
    .PAGE_TICKS (4),
    .BLINK_TICKS(3)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDATA       (iDATA),
    .iMODE       (iMODE),
    .iPAGE_SEL   (iPAGE_SEL),
    .iSTEP       (iSTEP),
    .iBLANK_LZ   (iBLANK_LZ),
    .iBLINK_MASK (iBLINK_MASK),
    .oSEG        (oSEG),
    .oPAGE       (oPAGE),
    .oWRAP       (oWRAP)
  );

  always #5 iCLK = ~iCLK;

  task automatic step(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  initial begin
    logic found;
    iRST = 1'b1;
    iDATA = {32'h00000A05, 32'hF0CAF0FA, 32'h12345678};
    iMODE = 2'd0;
    iPAGE_SEL = 4'd0;
    iSTEP = 1'b0;
    iBLANK_LZ = 1'b0;
    iBLINK_MASK = '0;
    step(2);
    chk("rst_seg", oSEG, {ND{7'h7F}});
    chk("rst_page", oPAGE, 4'd0);
    chk("rst_wrap", oWRAP, 1'b0);

    iRST = 1'b0;
    iPAGE_SEL = 4'd1;
    step(1);
    chk("static_p1_seg", oSEG,
        {7'h0E, 7'h40, 7'h46, 7'h08,
         7'h0E, 7'h40, 7'h0E, 7'h08});
    chk("static_p1_page", oPAGE, 4'd1);

    iPAGE_SEL = 4'd7;
    step(1);
    chk("clamp_page", oPAGE, 4'd2);

    iPAGE_SEL = 4'd0;
    step(1);
    chk("static_p0", oPAGE, 4'd0);
    chk("static_p0_seg", oSEG, {UP0, 7'h00});

    // auto scroll
    iMODE = 2'd1;
    step(4);
    chk("auto_hold0", oPAGE, 4'd0);
    step(1);
    chk("auto_p1", oPAGE, 4'd1);
    step(3);
    chk("auto_hold1", oPAGE, 4'd1);
    step(1);
    chk("auto_p2", oPAGE, 4'd2);
    step(3);
    chk("auto_nowrap", oWRAP, 1'b0);
    step(1);
    chk("auto_wrap_page", oPAGE, 4'd0);
    chk("auto_wrap_pulse", oWRAP, 1'b1);
    step(1);
    chk("auto_wrap_end", oWRAP, 1'b0);

    // manual: edge coincident with mode change is dropped
    iMODE = 2'd2;
    iSTEP = 1'b1;
    step(1);
    chk("man_modechg", oPAGE, 4'd0);
    iSTEP = 1'b0;
    step(1);
    iSTEP = 1'b1;
    step(1);
    chk("man_adv1", oPAGE, 4'd1);
    step(4);
    chk("man_held", oPAGE, 4'd1);
    iSTEP = 1'b0;
    step(1);
    iSTEP = 1'b1;
    step(1);
    chk("man_adv2", oPAGE, 4'd2);
    chk("man_nowrap", oWRAP, 1'b0);
    iSTEP = 1'b0;
    step(1);
    iSTEP = 1'b1;
    step(1);
    chk("man_wrap_page", oPAGE, 4'd0);
    chk("man_wrap_pulse", oWRAP, 1'b1);
    iSTEP = 1'b0;
    step(1);
    chk("man_wrap_end", oWRAP, 1'b0);

    // leading-zero blanking
    iMODE = 2'd0;
    iPAGE_SEL = 4'd2;
    iBLANK_LZ = 1'b1;
    step(1);
    chk("lz_a05", oSEG,
        {{5{7'h7F}}, 7'h08, 7'h40, 7'h12});
    iDATA[95:64] = 32'h0;
    step(1);
    chk("lz_zero", oSEG, {{7{7'h7F}}, 7'h40});
    iBLANK_LZ = 1'b0;
    step(1);
    chk("lz_off", oSEG, {8{7'h40}});

    // blink on digit 0
    iPAGE_SEL = 4'd0;
    iBLINK_MASK = 8'h01;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      found = (oSEG[6:0] == 7'h7F);
    end
    chk("blink_seen_blank", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      found = (oSEG[6:0] != 7'h7F);
    end
    chk("blink_seen_glyph", found, 1'b1);
    chk("blink_j0", oSEG, {UP0, 7'h00});
    iMODE = 2'd2;
    step(1);
    chk("blink_j1", oSEG, {UP0, 7'h00});
    step(1);
    chk("blink_j2", oSEG, {UP0, 7'h00});
    step(1);
    chk("blink_j3", oSEG, {UP0, 7'h7F});
    step(2);
    chk("blink_j5", oSEG, {UP0, 7'h7F});
    step(1);
    chk("blink_j6", oSEG, {UP0, 7'h00});

    // reset mid-operation, then auto from release
    iBLINK_MASK = '0;
    iMODE = 2'd1;
    step(6);
    @(posedge iCLK);
    #2 iRST = 1'b1;
    #1;
    chk("midrst_seg", oSEG, {ND{7'h7F}});
    chk("midrst_page", oPAGE, 4'd0);
    step(1);
    iRST = 1'b0;
    step(4);
    chk("postrst_hold", oPAGE, 4'd0);
    step(1);
    chk("postrst_adv", oPAGE, 4'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
